mem_wb_stage: RTL
=================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 5-stage pipeline CPU. It consumes the EXE/MEM register outputs and performs data-memory stores with per-byte lane enables and synchronous word loads. It selects the write-back value and registers the register-file write port for the WB stage. It honours the same stall (`we`) and flush (`clr`) controls as the other pipeline registers.

## Interface
- `DM_AW`, default 10: data-memory word-address width; depth = 2^DM_AW 32-bit words.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-high reset.
- `we`  in  1  stage enable; 0 = stall (hold all outputs, suppress memory write).
- `clr`  in  1  synchronous flush; inserts a bubble; priority over `we`.
- `RegWrite_in`  in  1  register-file write request from EXE/MEM.
- `mem_w_in`  in  1  store request.
- `wea_in`  in  4  byte-lane write enables; bit i covers data bits [8i+7:8i].
- `WDSel_in`  in  2  write-back select: 00 ALU, 01 memory, 10 PC+4, 11 reserved.
- `ALU_result_in`  in  32  effective address / ALU value.
- `ALU_B_in`  in  32  store data, already lane-aligned.
- `wregnum_in`  in  5  destination register.
- `PCPLUS4_in`  in  32  link value.
- `RegWrite_out`  out  1  registered write enable to the register file.
- `wregnum_out`  out  5  registered destination register.
- `WD_out`  out  32  registered write-back data.

## Operation
- Word index: `ALU_result_in[DM_AW+1:2]`. Bits [1:0] and bits above DM_AW+1 are ignored, so addresses wrap modulo the memory size. There is no misalignment check.
- Store: at a rising edge where `mem_w_in=1`, `we=1`, `clr=0` and `rst=0`, write each byte lane i with `wea_in[i]=1` from the same lane of `ALU_B_in`. Lanes with `wea_in[i]=0` keep their old contents. `wea_in=0000` with `mem_w_in=1` writes nothing.
- Load: the memory has a synchronous read port. At every enabled edge it captures the word at the current index into an internal read register.
  - Read-before-write: if a store and the read target the same word on the same edge, the read captures the old word.
- Alongside the read register, the stage registers `WDSel_in`, `ALU_result_in`, `PCPLUS4_in`, `RegWrite_in` and `wregnum_in`.
- `WD_out` is a mux over the registered values, selected by the registered WDSel:
  - 00: ALU result.
  - 01: read register.
  - 10: PC+4.
  - 11: 32'h0.
- Flush (`clr=1` at an edge): no memory write. All registered fields are set to 0, so `RegWrite_out=0`, `wregnum_out=0` and `WD_out=0`.
- Stall (`we=0`, `clr=0`): no memory write. All registered fields, including the read register, hold their values, so the outputs are unchanged.
- Reset (`rst=1`): all registered fields are cleared immediately and asynchronously. `RegWrite_out=0`, `wregnum_out=0`, `WD_out=0`.
  - Memory contents are not reset.
  - A reset asserted during a store edge suppresses that write.
- `RegWrite_in=1` with `wregnum_in=0` passes through unchanged; the register file ignores writes to r0.

## Timing
- Latency is 1 cycle. Inputs sampled at edge k appear on the outputs after edge k, stable for cycle k+1. A load's data is on `WD_out` in the same cycle as its `RegWrite_out`.
- A store takes effect at edge k. A load to the same word sampled at edge k+1 or later returns the new data.
- A load sampled at the same edge as a store returns the pre-store word. This cannot occur for a single in-order instruction stream; it is defined only for completeness.
- Simultaneous `clr=1` and `we=0`: flush wins.
- Reset release: the first enabled edge after `rst` falls loads normally.
- All outputs are registered or a mux over registers. There is no combinational path from inputs to outputs.

## Test plan
- Reset:
  - Stimulus: drive `rst=1` mid-cycle with nonzero state.
  - Required response: outputs go to 0 immediately without a clock edge; the first edge after release with an ALU op (WDSel=00, ALU=32'h1234, wreg=5, RegWrite=1) gives `WD_out=32'h1234`, `wregnum_out=5`.
- Store/load word:
  - Stimulus: store 32'hDEADBEEF at address 32'h40 with `wea=1111`; on the next cycle load 32'h40 with WDSel=01, wreg=8.
  - Required response: one cycle later `WD_out=32'hDEADBEEF`, `wregnum_out=8`, `RegWrite_out=1`.
- Byte lanes:
  - Stimulus: with word 32'h40 = 32'hDEADBEEF, store 32'h00AA0000 with `wea=0100`, then load 32'h40.
  - Required response: `WD_out=32'hDEAABEEF`.
- Wrap and PC+4:
  - Stimulus: store 32'h5 at address 32'h1000 (with DM_AW=10), then load address 32'h0.
  - Required response: the load returns 32'h5.
  - Stimulus: an op with WDSel=10 and PCPLUS4=32'h3008.
  - Required response: `WD_out=32'h3008`.
  - Stimulus: WDSel=11.
  - Required response: `WD_out=0`.
- Stall:
  - Stimulus: hold `we=0` for 3 cycles while presenting a store of 32'hFFFFFFFF to 32'h40.
  - Required response: outputs are frozen; a later load of 32'h40 shows the word unchanged.
- Flush:
  - Stimulus: `clr=1` with `we=0` while presenting a store plus RegWrite=1, wreg=9.
  - Required response: the memory is unchanged and the next outputs are `RegWrite_out=0`, `wregnum_out=0`, `WD_out=0`.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Bundles the EXE/MEM-side inputs and the registered write-back port of the MEM/WB stage.
// Ports: master drives the *_in fields and observes the *_out fields; slave (the stage) does the reverse.
// Carries no clock or reset; clk/rst and the we/clr controls stay plain ports on the stage.
interface mem_wb_stage_if;
  logic        RegWrite_in;
  logic        mem_w_in;
  logic [3:0]  wea_in;
  logic [1:0]  WDSel_in;
  logic [31:0] ALU_result_in;
  logic [31:0] ALU_B_in;
  logic [4:0]  wregnum_in;
  logic [31:0] PCPLUS4_in;
  logic        RegWrite_out;
  logic [4:0]  wregnum_out;
  logic [31:0] WD_out;

  modport master (
    output RegWrite_in, mem_w_in, wea_in, WDSel_in, ALU_result_in, ALU_B_in,
           wregnum_in, PCPLUS4_in,
    input  RegWrite_out, wregnum_out, WD_out
  );

  modport slave (
    input  RegWrite_in, mem_w_in, wea_in, WDSel_in, ALU_result_in, ALU_B_in,
           wregnum_in, PCPLUS4_in,
    output RegWrite_out, wregnum_out, WD_out
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB register: byte-lane stores, synchronous word loads, write-back select.
// Latency: 1 cycle from an enabled edge to RegWrite_out/wregnum_out/WD_out; outputs are a mux over registers only.
// Backpressure: we=0 stalls (state held, no store); clr=1 flushes to a bubble and wins over we.
// Ports: clk, rst (async active-high), we (stage enable), clr (sync flush), bus (slave side of mem_wb_stage_if).
module mem_wb_stage #(
  parameter int DM_AW = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic           clr,
  mem_wb_stage_if.slave  bus
);

  localparam int DEPTH = 1 << DM_AW;

  logic [31:0]      mem [0:DEPTH-1];
  logic [DM_AW-1:0] idx;
  logic             mem_wr;

  logic        regwrite_q;
  logic [4:0]  wreg_q;
  logic [1:0]  wdsel_q;
  logic [31:0] alu_q;
  logic [31:0] pc4_q;
  logic [31:0] rd_q;

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign idx = bus.ALU_result_in[DM_AW+1:2];

  // rst is sampled here too so that a reset overlapping a store edge blocks the write.
  assign mem_wr = bus.mem_w_in & we & ~clr & ~rst;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wea_in[i]) begin
          mem[idx][8*i +: 8] <= bus.ALU_B_in[8*i +: 8];
        end
      end
    end
  end

  // The read register samples mem[idx] with a non-blocking read, so a same-edge
  // store to that word is not visible yet (read-before-write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      wreg_q     <= 5'd0;
      wdsel_q    <= 2'b00;
      alu_q      <= 32'd0;
      pc4_q      <= 32'd0;
      rd_q       <= 32'd0;
    end else if (clr) begin
      regwrite_q <= 1'b0;
      wreg_q     <= 5'd0;
      wdsel_q    <= 2'b00;
      alu_q      <= 32'd0;
      pc4_q      <= 32'd0;
      rd_q       <= 32'd0;
    end else if (we) begin
      regwrite_q <= bus.RegWrite_in;
      wreg_q     <= bus.wregnum_in;
      wdsel_q    <= bus.WDSel_in;
      alu_q      <= bus.ALU_result_in;
      pc4_q      <= bus.PCPLUS4_in;
      rd_q       <= mem[idx];
    end
  end

  always_comb begin
    bus.WD_out = 32'd0;
    unique case (wdsel_q)
      2'b00:   bus.WD_out = alu_q;
      2'b01:   bus.WD_out = rd_q;
      2'b10:   bus.WD_out = pc4_q;
      default: bus.WD_out = 32'd0;
    endcase
  end

  assign bus.RegWrite_out = regwrite_q;
  assign bus.wregnum_out  = wreg_q;

endmodule
